// File: rtl/cla_pipe_adder_pkg.sv
// Shared constants and helpers for the pipelined carry-lookahead adder.
package cla_pipe_adder_pkg;

    localparam int unsigned DefWidth = 16;
    localparam int unsigned DefGroup = 4;

    // Per-bit generate/propagate pair, packed as {g, p}.
    function automatic logic [1:0] gp_bit(input logic a, input logic b);
        return {a & b, a ^ b};
    endfunction

    // Legal configuration: non-zero group that evenly divides the width.
    function automatic bit width_ok(input int unsigned width, input int unsigned group);
        return (group != 0) && (width >= group) && ((width % group) == 0);
    endfunction

endpackage

// File: rtl/cla_pipe_adder_if.sv
// Operand/result handshake bundle for cla_pipe_adder.
interface cla_pipe_adder_if #(
    parameter int unsigned WIDTH = 16
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

endinterface

// File: rtl/cla_pipe_adder_group.sv
// Combinational GROUP-bit carry-lookahead slice; carries are flattened sum-of-products.
module cla_pipe_adder_group
    import cla_pipe_adder_pkg::*;
#(
    parameter int unsigned GROUP = DefGroup
) (
    input  logic [GROUP-1:0] i_a,
    input  logic [GROUP-1:0] i_b,
    input  logic             i_ci,
    output logic [GROUP-1:0] o_s,
    output logic             o_co,
    output logic             o_c_msb_in
);

    logic [GROUP-1:0] w_g;
    logic [GROUP-1:0] w_p;
    logic [GROUP:0]   w_c;

    always_comb begin
        w_g = '0;
        w_p = '0;
        for (int i = 0; i < int'(GROUP); i++) begin
            {w_g[i], w_p[i]} = gp_bit(i_a[i], i_b[i]);
        end
    end

    // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]ci, no ripple chain
    always_comb begin : p_carry
        logic w_prod;
        w_c    = '0;
        w_prod = 1'b0;
        w_c[0] = i_ci;
        for (int i = 0; i < int'(GROUP); i++) begin
            w_c[i+1] = w_g[i];
            w_prod   = w_p[i];
            for (int j = i - 1; j >= 0; j--) begin
                w_c[i+1] = w_c[i+1] | (w_prod & w_g[j]);
                w_prod   = w_prod & w_p[j];
            end
            w_c[i+1] = w_c[i+1] | (w_prod & i_ci);
        end
    end

    assign o_s        = w_p ^ w_c[GROUP-1:0];
    assign o_co       = w_c[GROUP];
    assign o_c_msb_in = w_c[GROUP-1];

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined CLA adder/subtractor: one lookahead group per stage, carry registered between
// stages, whole pipe stalls together on output backpressure.
module cla_pipe_adder
    import cla_pipe_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned GROUP = DefGroup
) (
    input logic             clk,
    input logic             rst_n,
    cla_pipe_adder_if.slave s_if
);

    localparam int unsigned STAGES = WIDTH / GROUP;

    if (!width_ok(WIDTH, GROUP)) begin : g_bad_cfg
        $error("cla_pipe_adder: WIDTH must be a non-zero multiple of GROUP");
    end

    logic w_adv;

    assign w_adv         = !s_if.out_valid || s_if.out_ready;
    assign s_if.in_ready = w_adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned LoW  = k * GROUP;
        localparam int unsigned RemW = WIDTH - LoW;

        // Operand bits still unresolved on entry to this stage
        logic [RemW-1:0]      w_a_in;
        logic [RemW-1:0]      w_b_in;
        logic                 w_c_in;
        logic                 w_v_in;
        logic [LoW+GROUP-1:0] w_s_nxt;
        logic [GROUP-1:0]     w_gs;
        logic                 w_gco;
        logic                 w_gcm;
        logic                 r_v;
        logic [LoW+GROUP-1:0] r_s;

        if (k == 0) begin : g_head
            assign w_a_in  = s_if.a;
            assign w_b_in  = s_if.sub ? ~s_if.b : s_if.b;
            assign w_c_in  = s_if.sub | s_if.cin;
            assign w_v_in  = s_if.in_valid;
            assign w_s_nxt = w_gs;
        end else begin : g_body
            assign w_a_in  = g_stage[k-1].g_fwd.r_a;
            assign w_b_in  = g_stage[k-1].g_fwd.r_b;
            assign w_c_in  = g_stage[k-1].g_fwd.r_c;
            assign w_v_in  = g_stage[k-1].r_v;
            assign w_s_nxt = {w_gs, g_stage[k-1].r_s};
        end

        cla_pipe_adder_group #(
            .GROUP (GROUP)
        ) u_group (
            .i_a        (w_a_in[GROUP-1:0]),
            .i_b        (w_b_in[GROUP-1:0]),
            .i_ci       (w_c_in),
            .o_s        (w_gs),
            .o_co       (w_gco),
            .o_c_msb_in (w_gcm)
        );

        // Data only loads behind a valid beat so outputs hold across bubbles
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v <= 1'b0;
                r_s <= '0;
            end else if (w_adv) begin
                r_v <= w_v_in;
                if (w_v_in) begin
                    r_s <= w_s_nxt;
                end
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [RemW-GROUP-1:0] r_a;
            logic [RemW-GROUP-1:0] r_b;
            logic                  r_c;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a <= '0;
                    r_b <= '0;
                    r_c <= 1'b0;
                end else if (w_adv && w_v_in) begin
                    r_a <= w_a_in[RemW-1:GROUP];
                    r_b <= w_b_in[RemW-1:GROUP];
                    r_c <= w_gco;
                end
            end
        end else begin : g_tail
            logic r_cout;
            logic r_ovf;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cout <= 1'b0;
                    r_ovf  <= 1'b0;
                end else if (w_adv && w_v_in) begin
                    r_cout <= w_gco;
                    r_ovf  <= w_gcm ^ w_gco;
                end
            end
        end
    end

    assign s_if.out_valid = g_stage[STAGES-1].r_v;
    assign s_if.sum       = g_stage[STAGES-1].r_s;
    assign s_if.cout      = g_stage[STAGES-1].g_tail.r_cout;
    assign s_if.ovf       = g_stage[STAGES-1].g_tail.r_ovf;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder (WIDTH=16, GROUP=4) against an arithmetic model.
module tb_cla_pipe_adder;

    localparam int unsigned W   = 16;
    localparam int          LAT = 4;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    logic [17:0] exp_q[$];
    logic [17:0] obs_q[$];
    logic        iv_hist[$];
    logic        ov_hist[$];

    cla_pipe_adder_if #(.WIDTH(W)) bus ();

    cla_pipe_adder #(
        .WIDTH (W),
        .GROUP (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s_if  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog expired");
    end

    // Returns {cout, ovf, sum} from plain 17-bit arithmetic.
    function automatic logic [17:0] ref_add(input logic [15:0] a, input logic [15:0] b,
                                            input logic cin, input logic sub);
        logic [15:0] be;
        logic [16:0] full;
        logic        ov;
        be   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, be} + {16'd0, (sub | cin)};
        ov   = (a[15] == be[15]) && (full[15] != a[15]);
        return {full[16], ov, full[15:0]};
    endfunction

    // One clock cycle: drive at negedge, log handshakes, return before the posedge.
    task automatic step(input logic iv, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic sb, input logic ordy, output logic acc);
        @(negedge clk);
        bus.in_valid  = iv;
        bus.a         = a;
        bus.b         = b;
        bus.cin       = ci;
        bus.sub       = sb;
        bus.out_ready = ordy;
        #1;
        acc = iv & bus.in_ready;
        if (acc) exp_q.push_back(ref_add(a, b, ci, sb));
        if (bus.out_valid && ordy) obs_q.push_back({bus.cout, bus.ovf, bus.sum});
        iv_hist.push_back(acc);
        ov_hist.push_back(bus.out_valid);
    endtask

    task automatic clear_logs();
        exp_q.delete();
        obs_q.delete();
        iv_hist.delete();
        ov_hist.delete();
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (bus.out_valid !== 1'b0) begin
            n_err++; $display("FAIL reset out_valid: got %b want 0", bus.out_valid);
        end
        n_vec++;
        if ({bus.cout, bus.ovf, bus.sum} !== 18'd0) begin
            n_err++; $display("FAIL reset outputs: got %h want 0", {bus.cout, bus.ovf, bus.sum});
        end
        rst_n = 1'b1;
        #1;
        n_vec++;
        if (bus.in_ready !== 1'b1) begin
            n_err++; $display("FAIL reset in_ready: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_directed();
        logic [15:0] d_a[6];
        logic [15:0] d_b[6];
        logic        d_c[6];
        logic        d_sb[6];
        logic [17:0] d_exp[6];
        logic        acc;
        int          lat;
        d_a   = '{16'h0001, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000, 16'h0005};
        d_b   = '{16'h0002, 16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h0007};
        d_c   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        d_sb  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        d_exp = '{{2'b00, 16'h0003}, {2'b10, 16'h0000}, {2'b01, 16'h8000},
                  {2'b00, 16'hFFFE}, {2'b11, 16'h7FFF}, {2'b00, 16'hFFFE}};
        for (int i = 0; i < 6; i++) begin
            clear_logs();
            step(1'b1, d_a[i], d_b[i], d_c[i], d_sb[i], 1'b1, acc);
            lat = 0;
            for (int c = 1; c <= 10 && lat == 0; c++) begin
                step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, acc);
                if (bus.out_valid) lat = c;
            end
            n_vec++;
            if (lat != LAT) begin
                n_err++; $display("FAIL directed[%0d] latency: got %0d want %0d", i, lat, LAT);
            end
            n_vec++;
            if (obs_q.size() != 1) begin
                n_err++; $display("FAIL directed[%0d] count: got %0d want 1", i, obs_q.size());
            end else if (obs_q[0] !== d_exp[i]) begin
                n_err++;
                $display("FAIL directed[%0d] {cout,ovf,sum}: got %h want %h", i, obs_q[0], d_exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ta[16];
        logic [15:0] tbv[16];
        logic        tc[16];
        logic        ts[16];
        logic [17:0] snap;
        logic        acc;
        logic        ordy;
        int          idx;
        int          cyc;
        clear_logs();
        snap = '0;
        for (int i = 0; i < 16; i++) begin
            ta[i]  = 16'($urandom);
            tbv[i] = 16'($urandom);
            tc[i]  = 1'($urandom_range(0, 1));
            ts[i]  = 1'($urandom_range(0, 1));
        end
        idx = 0;
        cyc = 0;
        while (idx < 16 && cyc < 80) begin
            ordy = !(cyc >= 6 && cyc <= 8);
            step(1'b1, ta[idx], tbv[idx], tc[idx], ts[idx], ordy, acc);
            if (cyc == 6) snap = {bus.cout, bus.ovf, bus.sum};
            if (!ordy) begin
                n_vec++;
                if (bus.in_ready !== 1'b0) begin
                    n_err++; $display("FAIL stall in_ready c%0d: got %b want 0", cyc, bus.in_ready);
                end
                n_vec++;
                if (bus.out_valid !== 1'b1) begin
                    n_err++; $display("FAIL stall out_valid c%0d: got %b want 1", cyc, bus.out_valid);
                end
                if (cyc > 6) begin
                    n_vec++;
                    if ({bus.cout, bus.ovf, bus.sum} !== snap) begin
                        n_err++;
                        $display("FAIL stall hold c%0d: got %h want %h", cyc,
                                 {bus.cout, bus.ovf, bus.sum}, snap);
                    end
                end
            end
            if (acc) idx++;
            cyc++;
        end
        n_vec++;
        if (idx != 16) begin
            n_err++; $display("FAIL b2b accepted: got %0d want 16", idx);
        end
        for (int c = 0; c < 40 && obs_q.size() < 16; c++) begin
            step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, acc);
        end
        n_vec++;
        if (obs_q.size() != 16 || exp_q.size() != 16) begin
            n_err++;
            $display("FAIL b2b count: got %0d/%0d want 16/16", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL b2b beat[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_bubbles();
        logic acc;
        clear_logs();
        for (int c = 0; c < 40; c++) begin
            step(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, acc);
        end
        for (int c = 0; c < 5; c++) begin
            step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, acc);
        end
        for (int i = 0; i < 40; i++) begin
            n_vec++;
            if (ov_hist[i+LAT] !== iv_hist[i]) begin
                n_err++;
                $display("FAIL bubble valid[%0d]: got %b want %b", i, ov_hist[i+LAT], iv_hist[i]);
            end
        end
        n_vec++;
        if (obs_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL bubble count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL bubble beat[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        logic acc;
        int   lat;
        clear_logs();
        for (int c = 0; c < 5; c++) begin
            step(1'b1, 16'hF0F0, 16'h0F0F, 1'b0, 1'b0, 1'b1, acc);
        end
        n_vec++;
        if (bus.out_valid !== 1'b1) begin
            n_err++; $display("FAIL areset precondition out_valid: got %b want 1", bus.out_valid);
        end
        #1 rst_n = 1'b0;
        #1;
        n_vec++;
        if (bus.out_valid !== 1'b0) begin
            n_err++; $display("FAIL areset out_valid: got %b want 0", bus.out_valid);
        end
        n_vec++;
        if ({bus.cout, bus.ovf, bus.sum} !== 18'd0) begin
            n_err++; $display("FAIL areset outputs: got %h want 0", {bus.cout, bus.ovf, bus.sum});
        end
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_logs();
        step(1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b1, acc);
        lat = 0;
        for (int c = 1; c <= 10; c++) begin
            step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, acc);
            if (bus.out_valid && lat == 0) lat = c;
        end
        n_vec++;
        if (lat != LAT) begin
            n_err++; $display("FAIL areset latency: got %0d want %0d", lat, LAT);
        end
        n_vec++;
        if (obs_q.size() != 1) begin
            n_err++; $display("FAIL areset stale results: got %0d want 1", obs_q.size());
        end else if (obs_q[0] !== {2'b00, 16'h2345}) begin
            n_err++; $display("FAIL areset result: got %h want %h", obs_q[0], {2'b00, 16'h2345});
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_bubbles();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
